// File: rtl/control_pipe.sv
// Control pipeline: combinational opcode decode feeding DEPTH control stages (EX, MEM, ..., WB)
// with load-use stall and flush bubbles. Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes.
module control_pipe #(
  parameter int OPC_W  = 7,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_jalr,
  output logic              ex_jump,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc1,
  output logic              ex_ALUSrc2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic [1:0]        wb_WRFSel,
  output logic [REG_AW-1:0] wb_rd,
  output logic              illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       branch;
    logic       jalr;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] wrf_sel;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
  } stage_t;

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_IMM    = 5'b00100,
    OP_AUIPC  = 5'b00101,
    OP_STORE  = 5'b01000,
    OP_REG    = 5'b01100,
    OP_LUI    = 5'b01101,
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011
  } major_op_e;

  logic [4:0] major_op;
  ctrl_t      dec_ctrl;
  logic       dec_legal;
  logic       trap_kill;
  stage_t     stage1_d;
  stage_t     pipe_q [1:DEPTH];

  assign major_op = opcode[OPC_W-1:OPC_W-5];

  generate
    if (OPC_W > 5) begin : g_low_bits
      logic unused_opcode_low;
      assign unused_opcode_low = ^opcode[OPC_W-6:0];
    end
  endgenerate

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    case (major_op)
      OP_REG: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        dec_ctrl.wrf_sel   = 2'b10;
      end
      OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.alu_op    = 2'b11;
        dec_ctrl.wrf_sel   = 2'b10;
      end
      OP_LOAD: begin
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
      end
      OP_JAL: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.alu_src1  = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wrf_sel   = 2'b01;
      end
      OP_JALR: begin
        dec_ctrl.jalr      = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wrf_sel   = 2'b01;
      end
      OP_LUI: begin
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wrf_sel   = 2'b11;
      end
      OP_AUIPC: begin
        dec_ctrl.alu_src1  = 1'b1;
        dec_ctrl.alu_src2  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.wrf_sel   = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Load-use hazard against the load sitting in EX; a taken flush kills the consumer anyway.
  assign stall = in_valid && pipe_q[1].valid && pipe_q[1].ctrl.mem_read &&
                 (pipe_q[1].rd != '0) &&
                 ((pipe_q[1].rd == rs1) || (pipe_q[1].rd == rs2)) && !flush;

  assign trap_kill = TRAP_EN && !dec_legal;

  // Anything not entering EX as a live instruction is a fully zeroed bubble.
  always_comb begin
    stage1_d = '0;
    if (in_valid && !flush && !stall && !trap_kill) begin
      stage1_d.valid = 1'b1;
      stage1_d.ctrl  = dec_ctrl;
      stage1_d.rd    = rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor.
  // NOTE: the pipeline registers are reset because a stale valid/RegWrite after reset
  // would commit a phantom instruction; this is a few flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[1] <= stage1_d;
      for (int k = 2; k <= DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (in_valid && !flush && trap_kill) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign ex_valid     = pipe_q[1].valid;
  assign ex_branch    = pipe_q[1].ctrl.branch;
  assign ex_jalr      = pipe_q[1].ctrl.jalr;
  assign ex_jump      = pipe_q[1].ctrl.jump;
  assign ex_ALUOp     = pipe_q[1].ctrl.alu_op;
  assign ex_ALUSrc1   = pipe_q[1].ctrl.alu_src1;
  assign ex_ALUSrc2   = pipe_q[1].ctrl.alu_src2;
  assign ex_rd        = pipe_q[1].rd;

  assign mem_valid    = pipe_q[2].valid;
  assign mem_MemRead  = pipe_q[2].ctrl.mem_read;
  assign mem_MemWrite = pipe_q[2].ctrl.mem_write;

  assign wb_valid     = pipe_q[DEPTH].valid;
  assign wb_RegWrite  = pipe_q[DEPTH].ctrl.reg_write;
  assign wb_WRFSel    = pipe_q[DEPTH].ctrl.wrf_sel;
  assign wb_rd        = pipe_q[DEPTH].rd;

endmodule
